if_fetch: RTL and testbench
===========================

Name: if_fetch

Overview:
- Instruction fetch stage directly upstream of the IF/ID instruction buffer.
- Holds the PC and issues one aligned 64-bit fetch per request to instruction memory, at most one request outstanding.
- Splits each returned block into up to two instructions, each with its pc and npc, and hands them to the buffer with per-slot valid flags.
- Handles back-pressure (stop, instbuf_full) and pipeline redirects from the execute stage.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-low.
stop  in  1  pipeline stall from downstream.
instbuf_full  in  1  buffer cannot accept a new fetch block.
redirect_valid  in  1  branch/jump resolved mispredict; load redirect_pc.
redirect_pc  in  `PC_BUS  redirect target; bits [1:0] ignored and forced to 0.
imem_req  out  1  fetch request, one-cycle pulse, accepted unconditionally.
imem_addr  out  `PC_BUS  {pc[31:3],3'b000}.
imem_rvalid  in  1  response valid, at least 1 cycle after imem_req.
imem_rdata  in  64  response; [31:0] = word at addr, [63:32] = addr+4.
out1_inst / out1_pc / out1_npc  out  `INST_BUS / `PC_BUS / `PC_BUS  slot-1 instruction to buffer.
receive_flag1  out  1  slot 1 valid.
out2_inst / out2_pc / out2_npc  out  `INST_BUS / `PC_BUS / `PC_BUS  slot-2 instruction to buffer.
receive_flag2  out  1  slot 2 valid; never 1 while receive_flag1 is 0.

Behaviour:
- Reset (rst=0, async):
  - pc=RESET_PC; state=IDLE.
  - All out* registers 0; both receive flags 0.
  - imem_req=0.
- State IDLE:
  - imem_req = !stop && !instbuf_full && !redirect_valid && !flag_hold. This is combinational.
  - A request moves state to WAIT.
- State WAIT, on imem_rvalid:
  - Outputs are registered and appear the cycle after rvalid.
  - If pc[2]=0: out1 = rdata[31:0], pc, pc+4; out2 = rdata[63:32], pc+4, pc+8; both flags 1; pc += 8.
  - If pc[2]=1: out1 = rdata[63:32], pc, pc+4; flag1=1, flag2=0; pc += 4.
  - State moves to IDLE.
- Peak rate is one block every 2 cycles with 1-cycle memory latency.
- Flags pulse for one cycle.
  - If stop=1 in the cycle flags are high, flags and data hold (flag_hold) until the first cycle with stop=0, then clear.
  - No new request while flag_hold=1.
- Redirect has highest priority, in any state:
  - pc = {redirect_pc[31:2],2'b00}.
  - Flags and flag_hold cleared next cycle; out* data don't-care.
  - WAIT without rvalid in the same cycle: go to DROP.
  - WAIT with rvalid in the same cycle: response discarded, go to IDLE.
  - IDLE: stay IDLE; no request this cycle.
  - DROP: stay DROP, pc updated.
- State DROP: next imem_rvalid is discarded with no flags; go to IDLE.
- instbuf_full only blocks new requests. An in-flight response is always delivered, so the buffer must reserve space for one block.
- stop and instbuf_full never cancel an outstanding request.
- imem_rvalid in IDLE is illegal; ignored.
- npc arithmetic is 32-bit modulo; wrap at 0xFFFF_FFFC to 0 is legal.

Optional Feature:
- IF_STATIC_BP_EN defined: static prediction on delivered slots.
  - B-type (opcode 1100011) with inst[31]=1 (backward): npc = pc + B-imm.
  - JAL (opcode 1101111): npc = pc + J-imm.
  - Fetch pc is loaded with the first predicted-taken target instead of the sequential value.
  - If slot 1 is predicted taken, slot 2 is suppressed (flag2=0).
  - Redirect still overrides.
- Not defined: npc is always sequential; fetch pc advances by 8 or 4 only.

Decomposition:
- def.vh holds:
  - `PC_BUS, `INST_BUS.
  - Fetch state encodings IDLE/WAIT/DROP (2 bits).
  - Opcode constants OP_BRANCH, OP_JAL.
  - Fetch block width 64.
- One sub-module, if_predecode: combinational per-slot taken/target computation.
  - Instantiated twice, only under IF_STATIC_BP_EN.

Test Plan:
- Reset release, RESET_PC=0, memory latency 1, no stalls -> req at addr 0, 8, 16 every 2 cycles; each block gives flag1=flag2=1, out1_pc=0, out2_pc=4, out2_npc=8.
- Redirect to 0x104 -> imem_addr=0x100; flag1 only; out1_inst=rdata[63:32], out1_pc=0x104, npc=0x108; next req addr=0x108.
- Redirect in WAIT, rvalid 3 cycles later -> that response yields no flags; next request goes to the redirect target; redirect coincident with rvalid also drops the data.
- stop=1 held 4 cycles as flags rise -> flags and data stay stable 4 cycles, clear after stop falls; no imem_req meanwhile.
- instbuf_full=1 asserted during WAIT -> outstanding block still delivered; no further req until full=0.
- IF_STATIC_BP_EN: slot1 = BEQ with imm=-16 at pc 0x20 -> out1_npc=0x10, flag2=0, next req addr=0x10.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// Shared widths, fetch state encoding, opcode constants and immediate decoders for the fetch stage.
package if_fetch_pkg;

  localparam int unsigned PC_W    = 32;
  localparam int unsigned INST_W  = 32;
  localparam int unsigned BLOCK_W = 64;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   npc;
  } fetch_slot_t;

  function automatic logic [PC_W-1:0] b_imm(input logic [INST_W-1:0] inst);
    return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

  function automatic logic [PC_W-1:0] j_imm(input logic [INST_W-1:0] inst);
    return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/if_predecode.sv
// Per-slot static predictor: backward conditional branches and JAL are predicted taken.
module if_predecode
  import if_fetch_pkg::*;
(
  input  logic [INST_W-1:0] inst,
  input  logic [PC_W-1:0]   pc,
  output logic              taken_c,
  output logic [PC_W-1:0]   target_c
);

  logic is_bwd_branch;
  logic is_jal;

  always_comb begin
    is_bwd_branch = (inst[6:0] == OP_BRANCH) && inst[31];
    is_jal        = (inst[6:0] == OP_JAL);
    taken_c       = is_bwd_branch || is_jal;
    target_c      = pc + (is_jal ? j_imm(inst) : b_imm(inst));
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage: one 64-bit block request in flight, split into up to two slots.
// Optional static branch prediction is built when IF_STATIC_BP_EN is defined.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stop,
  input  logic               instbuf_full,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_rvalid,
  input  logic [BLOCK_W-1:0] imem_rdata,
  output logic [INST_W-1:0]  out1_inst,
  output logic [PC_W-1:0]    out1_pc,
  output logic [PC_W-1:0]    out1_npc,
  output logic               receive_flag1,
  output logic [INST_W-1:0]  out2_inst,
  output logic [PC_W-1:0]    out2_pc,
  output logic [PC_W-1:0]    out2_npc,
  output logic               receive_flag2
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, pc_plus4, pc_plus8, next_pc, redir_pc;
  logic [INST_W-1:0] inst_lo, inst_hi, slot1_inst;
  fetch_slot_t     slot1_q, slot2_q, slot1_d, slot2_d, blk1, blk2;
  logic            flag1_q, flag2_q, flag1_d, flag2_d, hold_q, hold_d;
  logic            dual, deliver;

`ifdef IF_STATIC_BP_EN
  logic            taken1, taken2;
  logic [PC_W-1:0] target1, target2;

  if_predecode u_pd1 (.inst(slot1_inst), .pc(pc_q),     .taken_c(taken1), .target_c(target1));
  if_predecode u_pd2 (.inst(inst_hi),    .pc(pc_plus4), .taken_c(taken2), .target_c(target2));
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state; a redirect racing a response consumes that response
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (imem_req) state_d = WAIT;
      WAIT: begin
        if (redirect_valid) state_d = imem_rvalid ? IDLE : DROP;
        else if (imem_rvalid) state_d = IDLE;
      end
      DROP:    if (imem_rvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request outputs
  always_comb begin
    imem_req  = rst && (state_q == IDLE) && !stop && !instbuf_full
                && !redirect_valid && !hold_q;
    imem_addr = {pc_q[PC_W-1:3], 3'b000};
  end

  // Split the returned block into slots and pick the next fetch pc
  always_comb begin
    inst_lo    = imem_rdata[INST_W-1:0];
    inst_hi    = imem_rdata[BLOCK_W-1:INST_W];
    pc_plus4   = pc_q + PC_W'(4);
    pc_plus8   = pc_q + PC_W'(8);
    slot1_inst = pc_q[2] ? inst_hi : inst_lo;
    dual       = !pc_q[2];
    blk1.inst  = slot1_inst;
    blk1.pc    = pc_q;
    blk1.npc   = pc_plus4;
    blk2.inst  = inst_hi;
    blk2.pc    = pc_plus4;
    blk2.npc   = pc_plus8;
    next_pc    = dual ? pc_plus8 : pc_plus4;
`ifdef IF_STATIC_BP_EN
    if (taken1) begin
      blk1.npc = target1;
      dual     = 1'b0;
      next_pc  = target1;
    end else if (dual && taken2) begin
      blk2.npc = target2;
      next_pc  = target2;
    end
`endif
  end

  // Datapath next values: redirect, delivery, stall-hold, or flag clear
  always_comb begin
    redir_pc = redirect_pc & ~PC_W'(3);
    deliver  = (state_q == WAIT) && imem_rvalid;
    pc_d     = pc_q;
    slot1_d  = slot1_q;
    slot2_d  = slot2_q;
    flag1_d  = 1'b0;
    flag2_d  = 1'b0;
    hold_d   = 1'b0;
    if (redirect_valid) begin
      pc_d = redir_pc;
    end else if (deliver) begin
      pc_d    = next_pc;
      slot1_d = blk1;
      slot2_d = blk2;
      flag1_d = 1'b1;
      flag2_d = dual;
    end else if (flag1_q && stop) begin
      flag1_d = flag1_q;
      flag2_d = flag2_q;
      hold_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= RESET_PC;
      slot1_q <= '0;
      slot2_q <= '0;
      flag1_q <= 1'b0;
      flag2_q <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      slot1_q <= slot1_d;
      slot2_q <= slot2_d;
      flag1_q <= flag1_d;
      flag2_q <= flag2_d;
      hold_q  <= hold_d;
    end
  end

  assign out1_inst     = slot1_q.inst;
  assign out1_pc       = slot1_q.pc;
  assign out1_npc      = slot1_q.npc;
  assign out2_inst     = slot2_q.inst;
  assign out2_pc       = slot2_q.pc;
  assign out2_npc      = slot2_q.npc;
  assign receive_flag1 = flag1_q;
  assign receive_flag2 = flag2_q;

endmodule

// File: tb/tb_if_fetch.sv
// Randomized bench for if_fetch: address-level memory model and transaction-level fetch reference.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stop = 1'b0;
  logic        instbuf_full = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [63:0] imem_rdata = '0;
  logic [31:0] out1_inst, out1_pc, out1_npc, out2_inst, out2_pc, out2_npc;
  logic        receive_flag1, receive_flag2;

  if_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .stop(stop), .instbuf_full(instbuf_full),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .out1_inst(out1_inst), .out1_pc(out1_pc), .out1_npc(out1_npc),
    .receive_flag1(receive_flag1),
    .out2_inst(out2_inst), .out2_pc(out2_pc), .out2_npc(out2_npc),
    .receive_flag2(receive_flag2)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned n_deliv = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Memory contents are a fixed hash of the word address
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0F0F_5A5A;
  endfunction

`ifdef IF_STATIC_BP_EN
  function automatic bit predict(input logic [31:0] inst, input logic [31:0] pc,
                                 output logic [31:0] tgt);
    int imm;
    if (inst[6:0] == 7'b1101111) begin
      imm = (inst[31] ? -(1 << 20) : 0) + int'(inst[19:12]) * 4096
            + int'(inst[20]) * 2048 + int'(inst[30:21]) * 2;
      tgt = pc + 32'(imm);
      return 1'b1;
    end
    if (inst[6:0] == 7'b1100011 && inst[31]) begin
      imm = -4096 + int'(inst[7]) * 2048 + int'(inst[30:25]) * 32 + int'(inst[11:8]) * 2;
      tgt = pc + 32'(imm);
      return 1'b1;
    end
    tgt = '0;
    return 1'b0;
  endfunction
`endif

  // Reference state: architectural fetch pc, in-flight/poisoned request, visible slots
  logic [31:0] m_pc = '0;
  bit          m_busy = 0, m_poison = 0, m_hold = 0, m_f1 = 0, m_f2 = 0;
  logic [31:0] m_i1, m_p1, m_n1, m_i2, m_p2, m_n2;

  // Memory responder state
  bit          r_pend = 0;
  int          r_cnt = 0;
  int          r_lat = 1;
  logic [31:0] r_addr = '0;
  int          stop_left = 0;
  int          full_left = 0;

  task automatic deliver();
    logic [31:0] a, nxt, tgt;
    bit taken;
    a = m_pc; taken = 0; nxt = a + 32'd4; tgt = '0;
    m_f1 = 1; m_i1 = word_at(a); m_p1 = a; m_n1 = a + 32'd4;
`ifdef IF_STATIC_BP_EN
    if (predict(m_i1, a, tgt)) begin taken = 1; m_n1 = tgt; nxt = tgt; end
`endif
    m_f2 = 0;
    if (a[2] == 1'b0 && !taken) begin
      m_f2 = 1; m_i2 = word_at(a + 32'd4); m_p2 = a + 32'd4; m_n2 = a + 32'd8; nxt = a + 32'd8;
`ifdef IF_STATIC_BP_EN
      if (predict(m_i2, a + 32'd4, tgt)) begin m_n2 = tgt; nxt = tgt; end
`endif
    end
    m_pc = nxt;
    n_deliv++;
  endtask

  task automatic drive(input int cyc);
    if (r_pend && r_cnt == 1) begin
      imem_rvalid = 1'b1;
      imem_rdata  = {word_at(r_addr + 32'd4), word_at(r_addr)};
      r_pend      = 0;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = {$urandom, $urandom};
      if (r_pend) r_cnt--;
    end
    stop = 1'b0; instbuf_full = 1'b0; redirect_valid = 1'b0;
    redirect_pc = $urandom;
    if (cyc < 40) begin
      r_lat = 1;
    end else begin
      r_lat = int'($urandom_range(1, 4));
      if (cyc == 40) begin
        redirect_valid = 1'b1; redirect_pc = 32'h104 | 32'($urandom_range(0, 3));
      end else if (cyc == 400) begin
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
      end else if (cyc > 60 && $urandom_range(0, 23) == 0) begin
        redirect_valid = 1'b1;
        if ($urandom_range(0, 1) == 0) redirect_pc = redirect_pc & 32'h0000_FFFF;
      end
      if (stop_left > 0) stop_left--;
      else if ($urandom_range(0, 9) == 0) stop_left = int'($urandom_range(1, 5));
      stop = (stop_left > 0);
      if (full_left > 0) full_left--;
      else if ($urandom_range(0, 11) == 0) full_left = int'($urandom_range(1, 6));
      instbuf_full = (full_left > 0);
    end
  endtask

  task automatic step_model();
    bit exp_req;
    exp_req = !m_busy && !stop && !instbuf_full && !redirect_valid && !m_hold;
    check("imem_req", 32'(imem_req), 32'(exp_req));
    if (exp_req) check("imem_addr", imem_addr, m_pc & ~32'h7);
    check("flags", {30'd0, receive_flag2, receive_flag1}, {30'd0, m_f2, m_f1});
    if (m_f1) begin
      check("out1_inst", out1_inst, m_i1);
      check("out1_pc", out1_pc, m_p1);
      check("out1_npc", out1_npc, m_n1);
    end
    if (m_f2) begin
      check("out2_inst", out2_inst, m_i2);
      check("out2_pc", out2_pc, m_p2);
      check("out2_npc", out2_npc, m_n2);
    end
    if (imem_req) begin r_pend = 1; r_cnt = r_lat; r_addr = imem_addr; end
    if (redirect_valid) begin
      m_pc = redirect_pc & ~32'h3; m_f1 = 0; m_f2 = 0; m_hold = 0;
      if (imem_rvalid) begin m_busy = 0; m_poison = 0; end
      else if (m_busy) m_poison = 1;
    end else if (imem_rvalid && m_busy) begin
      if (m_poison) begin m_f1 = 0; m_f2 = 0; end
      else deliver();
      m_busy = 0; m_poison = 0; m_hold = 0;
    end else if (m_f1 && stop) begin
      m_hold = 1;
    end else begin
      m_f1 = 0; m_f2 = 0; m_hold = 0;
    end
    if (exp_req) m_busy = 1;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_flags", {30'd0, receive_flag2, receive_flag1}, 32'd0);
      check("rst_req", 32'(imem_req), 32'd0);
    end
    check("rst_addr", imem_addr, 32'd0);
    check("rst_out1_inst", out1_inst, 32'd0);
    check("rst_out1_pc", out1_pc, 32'd0);
    check("rst_out1_npc", out1_npc, 32'd0);
    check("rst_out2_inst", out2_inst, 32'd0);
    check("rst_out2_pc", out2_pc, 32'd0);
    check("rst_out2_npc", out2_npc, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      drive(cyc);
      @(negedge clk);
      step_model();
      @(posedge clk); #1;
    end
    check("deliveries_seen", 32'(n_deliv > 200), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
